bdu_bit_streamer: RTL and testbench

- Transmit side of the BDU bit-serial interface.
- Holds one query point and accepts reference points over a valid/ready handshake.
- Serializes each query/reference pair MSB-first, interleaved x,y,z per bit position, driving valid/q_bit/r_bit/code/b into one BDU.
- Watches the BDU's terminate/done, aborts or retires the current reference, and reports the outcome tagged with the reference ID.

---
 rtl/bdu_bit_streamer_pkg.sv | 31 +++
 rtl/bdu_bit_streamer_if.sv | 58 +++++
 rtl/bdu_bit_streamer.sv | 179 +++++++++++++++++
 tb/tb_bdu_bit_streamer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bdu_bit_streamer_pkg.sv
// rtl/bdu_bit_streamer_pkg.sv - shared constants and types for the BDU bit streamer
package bdu_pkg;

  localparam int B_DEFAULT    = 32;
  localparam int ID_W_DEFAULT = 16;

  // Dimension codes carried on the code lines alongside each beat
  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_X    = 2'b01;
  localparam logic [1:0] CODE_Y    = 2'b10;
  localparam logic [1:0] CODE_Z    = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2
  } stream_state_e;

  // Point layout at the default coordinate width
  typedef struct packed {
    logic [B_DEFAULT-1:0] x;
    logic [B_DEFAULT-1:0] y;
    logic [B_DEFAULT-1:0] z;
  } point_t;

  // Beats walk x, y, z for one bit position before moving to the next bit
  function automatic logic [1:0] next_code(input logic [1:0] code);
    return (code == CODE_Z) ? CODE_X : code + 2'd1;
  endfunction

endpackage

// File: rtl/bdu_bit_streamer_if.sv
// rtl/bdu_bit_streamer_if.sv - query/reference intake, BDU beat link and retire report
interface bdu_bit_streamer_if #(
  parameter int B    = 32,
  parameter int ID_W = 16
);

  localparam int BW = $clog2(B);
  localparam int CW = $clog2(3 * B + 1);

  // Query load
  logic            q_load;
  logic [B-1:0]    q_x_in;
  logic [B-1:0]    q_y_in;
  logic [B-1:0]    q_z_in;

  // Reference handshake
  logic            ref_valid;
  logic            ref_ready;
  logic [B-1:0]    ref_x;
  logic [B-1:0]    ref_y;
  logic [B-1:0]    ref_z;
  logic [ID_W-1:0] ref_id;

  // Beat link to the BDU
  logic            valid;
  logic            q_bit;
  logic            r_bit;
  logic [1:0]      code;
  logic [BW-1:0]   b;
  logic            terminate;
  logic            done;

  // Outcome report
  logic            retire_valid;
  logic            retire_hit;
  logic [ID_W-1:0] retire_id;
  logic [CW-1:0]   retire_beats;
  logic            busy;

  modport master (
    input  q_load, q_x_in, q_y_in, q_z_in,
    input  ref_valid, ref_x, ref_y, ref_z, ref_id,
    input  terminate, done,
    output ref_ready,
    output valid, q_bit, r_bit, code, b,
    output retire_valid, retire_hit, retire_id, retire_beats, busy
  );

  modport slave (
    output q_load, q_x_in, q_y_in, q_z_in,
    output ref_valid, ref_x, ref_y, ref_z, ref_id,
    output terminate, done,
    input  ref_ready,
    input  valid, q_bit, r_bit, code, b,
    input  retire_valid, retire_hit, retire_id, retire_beats, busy
  );

endinterface

// File: rtl/bdu_bit_streamer.sv
// rtl/bdu_bit_streamer.sv - serializes query/reference pairs MSB-first into one BDU
module bdu_bit_streamer
  import bdu_pkg::*;
#(
  parameter int B    = B_DEFAULT,
  parameter int ID_W = ID_W_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  bdu_bit_streamer_if.master  bus
);

  localparam int BW     = $clog2(B);
  localparam int CW     = $clog2(3 * B + 1);
  localparam int NBEATS = 3 * B;

  typedef struct packed {
    logic [B-1:0] x;
    logic [B-1:0] y;
    logic [B-1:0] z;
  } coord_t;

  stream_state_e   state_q;
  coord_t          query_q;
  coord_t          ref_q;
  logic            query_loaded_q;
  logic [ID_W-1:0] id_q;
  logic [CW-1:0]   beats_q;

  logic            ref_ready_q;
  logic            valid_q;
  logic            q_bit_q;
  logic            r_bit_q;
  logic [1:0]      code_q;
  logic [BW-1:0]   b_q;
  logic            retire_valid_q;
  logic            retire_hit_q;
  logic [ID_W-1:0] retire_id_q;
  logic [CW-1:0]   retire_beats_q;
  logic            busy_q;

  coord_t          q_src_d;
  coord_t          r_src_d;
  logic [1:0]      code_d;
  logic [BW-1:0]   b_d;
  logic            first_q_bit_d;
  logic            first_r_bit_d;
  logic            step_q_bit_d;
  logic            step_r_bit_d;

  // Picks coordinate bit (B-1-bi) of the dimension named by code
  function automatic logic sel_bit(input coord_t p, input logic [1:0] code,
                                   input logic [BW-1:0] bi);
    logic [BW-1:0] ridx;
    ridx = BW'(B - 1) - bi;
    case (code)
      CODE_X:  sel_bit = p.x[ridx];
      CODE_Y:  sel_bit = p.y[ridx];
      CODE_Z:  sel_bit = p.z[ridx];
      default: sel_bit = 1'b0;
    endcase
  endfunction

  // Bit mux for the first beat (fresh operands) and for the following beat
  always_comb begin
    q_src_d = query_q;
    if (bus.q_load) begin
      q_src_d = '{x: bus.q_x_in, y: bus.q_y_in, z: bus.q_z_in};
    end
    r_src_d = '{x: bus.ref_x, y: bus.ref_y, z: bus.ref_z};

    code_d = next_code(code_q);
    b_d    = (code_q == CODE_Z) ? b_q + 1'b1 : b_q;

    first_q_bit_d = sel_bit(q_src_d, CODE_X, '0);
    first_r_bit_d = sel_bit(r_src_d, CODE_X, '0);
    step_q_bit_d  = sel_bit(query_q, code_d, b_d);
    step_r_bit_d  = sel_bit(ref_q, code_d, b_d);
  end

  // Streamer FSM: accept, one beat per cycle, wait for the BDU verdict, retire
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      query_q        <= '0;
      ref_q          <= '0;
      query_loaded_q <= 1'b0;
      id_q           <= '0;
      beats_q        <= '0;
      ref_ready_q    <= 1'b0;
      valid_q        <= 1'b0;
      q_bit_q        <= 1'b0;
      r_bit_q        <= 1'b0;
      code_q         <= CODE_NONE;
      b_q            <= '0;
      retire_valid_q <= 1'b0;
      retire_hit_q   <= 1'b0;
      retire_id_q    <= '0;
      retire_beats_q <= '0;
      busy_q         <= 1'b0;
    end else begin
      retire_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.q_load) begin
            query_q        <= q_src_d;
            query_loaded_q <= 1'b1;
          end
          if (bus.ref_valid && ref_ready_q) begin
            ref_q       <= r_src_d;
            id_q        <= bus.ref_id;
            beats_q     <= CW'(1);
            state_q     <= STREAM;
            ref_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            valid_q     <= 1'b1;
            code_q      <= CODE_X;
            b_q         <= '0;
            q_bit_q     <= first_q_bit_d;
            r_bit_q     <= first_r_bit_d;
          end else begin
            ref_ready_q <= query_loaded_q | bus.q_load;
          end
        end
        STREAM, WAIT: begin
          if (bus.terminate || bus.done) begin
            // Terminate wins when both arrive together
            retire_valid_q <= 1'b1;
            retire_hit_q   <= bus.done & ~bus.terminate;
            retire_id_q    <= id_q;
            retire_beats_q <= beats_q;
            state_q        <= IDLE;
            ref_ready_q    <= query_loaded_q;
            busy_q         <= 1'b0;
            valid_q        <= 1'b0;
            q_bit_q        <= 1'b0;
            r_bit_q        <= 1'b0;
            code_q         <= CODE_NONE;
            b_q            <= '0;
          end else if (state_q == STREAM) begin
            if (beats_q == CW'(NBEATS)) begin
              state_q <= WAIT;
              valid_q <= 1'b0;
              q_bit_q <= 1'b0;
              r_bit_q <= 1'b0;
              code_q  <= CODE_NONE;
              b_q     <= '0;
            end else begin
              beats_q <= beats_q + 1'b1;
              code_q  <= code_d;
              b_q     <= b_d;
              q_bit_q <= step_q_bit_d;
              r_bit_q <= step_r_bit_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A BDU may only declare a hit once it has seen every beat
  early_done_chk : assert property (@(posedge clk) disable iff (rst)
    !(state_q == STREAM && bus.done && !bus.terminate && beats_q < CW'(NBEATS)))
    else $error("bdu_bit_streamer: done before all beats were sent");

  assign bus.ref_ready    = ref_ready_q;
  assign bus.valid        = valid_q;
  assign bus.q_bit        = q_bit_q;
  assign bus.r_bit        = r_bit_q;
  assign bus.code         = code_q;
  assign bus.b            = b_q;
  assign bus.retire_valid = retire_valid_q;
  assign bus.retire_hit   = retire_hit_q;
  assign bus.retire_id    = retire_id_q;
  assign bus.retire_beats = retire_beats_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_bdu_bit_streamer.sv
// tb/tb_bdu_bit_streamer.sv - self-checking bench for bdu_bit_streamer
module tb_bdu_bit_streamer;
  import bdu_pkg::*;

  localparam int B    = 4;
  localparam int ID_W = 16;
  localparam int NB   = 3 * B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bdu_bit_streamer_if #(.B(B), .ID_W(ID_W)) bus ();
  bdu_bit_streamer #(.B(B), .ID_W(ID_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit              ld;
    logic [B-1:0]    qx, qy, qz;
    logic [B-1:0]    rx, ry, rz;
    logic [ID_W-1:0] id;
    int              term_at;
    bit              both;
    bit              stray;
    bit              gold;
    bit              hit;
    int              beats;
    int              lat;
  } scen_t;

  int total = 0;
  int bad   = 0;

  logic [B-1:0] mqx, mqy, mqz;
  logic [5:0]   exp_q[$];
  logic [5:0]   golden[12];
  scen_t        sc[6];
  scen_t        s1, s2;
  int           w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {q_bit, r_bit, code, b} of beat k
  function automatic logic [5:0] model_beat(input logic [B-1:0] q0, q1, q2, r0, r1, r2,
                                            input int k);
    int d, bi;
    logic [B-1:0] qv, rv;
    d  = k % 3;
    bi = k / 3;
    qv = (d == 0) ? q0 : (d == 1) ? q1 : q2;
    rv = (d == 0) ? r0 : (d == 1) ? r1 : r2;
    return {qv[B-1-bi], rv[B-1-bi], 2'(d + 1), 2'(bi)};
  endfunction

  // Offers one reference, acts as the BDU, and checks every beat plus the retire report
  task automatic run_one(input scen_t s, input bit hold_next,
                         input logic [B-1:0] nrx, nry, nrz, input logic [ID_W-1:0] nid,
                         output int wait_cnt);
    bit accepted;
    bit fin;
    int seen;
    logic [5:0] e;
    bus.ref_x = s.rx; bus.ref_y = s.ry; bus.ref_z = s.rz; bus.ref_id = s.id;
    bus.ref_valid = 1'b1;
    if (s.ld) begin
      bus.q_load = 1'b1;
      bus.q_x_in = s.qx; bus.q_y_in = s.qy; bus.q_z_in = s.qz;
      mqx = s.qx; mqy = s.qy; mqz = s.qz;
    end
    accepted = 1'b0;
    wait_cnt = 0;
    for (int i = 0; i < 30 && !accepted; i++) begin
      if (bus.ref_ready) accepted = 1'b1;
      else wait_cnt++;
      tick();
      bus.q_load = 1'b0;
    end
    if (!accepted) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    for (int k = 0; k < NB; k++)
      exp_q.push_back(s.gold ? golden[k] : model_beat(mqx, mqy, mqz, s.rx, s.ry, s.rz, k));
    if (hold_next) begin
      bus.ref_x = nrx; bus.ref_y = nry; bus.ref_z = nrz; bus.ref_id = nid;
    end else begin
      bus.ref_valid = 1'b0;
    end
    fin  = 1'b0;
    seen = 0;
    for (int c = 1; c <= 60 && !fin; c++) begin
      if (bus.valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {bus.q_bit, bus.r_bit, bus.code, bus.b}, e);
        end
        seen++;
        if (seen == 1) chk("busy", bus.busy, 1);
      end
      if (bus.retire_valid) begin
        chk("ret_hit", bus.retire_hit, s.hit);
        chk("ret_id", bus.retire_id, s.id);
        chk("ret_beats", bus.retire_beats, s.beats);
        chk("ret_latency", c, s.lat);
        chk("ret_ready", bus.ref_ready, 1);
        chk("ret_valid_low", bus.valid, 0);
        if (s.term_at == 0) chk("beats_left", exp_q.size(), 0);
        exp_q.delete();
        bus.terminate = 1'b0;
        bus.done      = 1'b0;
        bus.q_load    = 1'b0;
        fin = 1'b1;
      end else begin
        bus.terminate = (s.term_at > 0 && bus.valid && seen == s.term_at) ||
                        (s.both && !bus.valid && seen == NB);
        bus.done      = (s.term_at == 0 && !bus.valid && seen == NB);
        bus.q_load    = s.stray && bus.valid && seen == 2;
        bus.q_x_in = ~mqx; bus.q_y_in = ~mqy; bus.q_z_in = ~mqz;
        tick();
      end
    end
    if (!fin) chk("retire_timeout", 0, 1);
  endtask

  initial begin
    golden = '{6'b10_01_00, 6'b00_10_00, 6'b10_11_00,
               6'b01_01_01, 6'b00_10_01, 6'b10_11_01,
               6'b10_01_10, 6'b11_10_10, 6'b10_11_10,
               6'b01_01_11, 6'b11_10_11, 6'b10_11_11};
    //          ld    qx    qy    qz    rx    ry    rz    id         term both stray gold hit beats lat
    sc[0] = '{1'b0, 4'hA, 4'h3, 4'hF, 4'h5, 4'h3, 4'h0, 16'd7,     0,  1'b0, 1'b0, 1'b1, 1'b1, 12, 14};
    sc[1] = '{1'b0, 4'hA, 4'h3, 4'hF, 4'h5, 4'h3, 4'h0, 16'd7,     5,  1'b0, 1'b0, 1'b1, 1'b0,  5,  6};
    sc[2] = '{1'b0, 4'hA, 4'h3, 4'hF, 4'h5, 4'h3, 4'h0, 16'd7,     0,  1'b1, 1'b1, 1'b1, 1'b0, 12, 14};
    sc[3] = '{1'b0, 4'hA, 4'h3, 4'hF, 4'hC, 4'h9, 4'h6, 16'h1234,  1,  1'b0, 1'b0, 1'b0, 1'b0,  1,  2};
    sc[4] = '{1'b0, 4'hA, 4'h3, 4'hF, 4'hF, 4'h0, 4'hA, 16'hFFFF,  12, 1'b0, 1'b0, 1'b0, 1'b0, 12, 13};
    sc[5] = '{1'b1, 4'h6, 4'h9, 4'h1, 4'h3, 4'hE, 4'h8, 16'h0055,  0,  1'b0, 1'b0, 1'b0, 1'b1, 12, 14};
    s1    = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h3, 4'h0, 16'd1,     3,  1'b0, 1'b0, 1'b0, 1'b0,  3,  4};
    s2    = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h9, 4'h9, 4'h9, 16'd2,     0,  1'b0, 1'b0, 1'b0, 1'b1, 12, 14};

    bus.q_load = 1'b0; bus.q_x_in = '0; bus.q_y_in = '0; bus.q_z_in = '0;
    bus.ref_valid = 1'b0; bus.ref_x = '0; bus.ref_y = '0; bus.ref_z = '0; bus.ref_id = '0;
    bus.terminate = 1'b0; bus.done = 1'b0;
    mqx = '0; mqy = '0; mqz = '0;

    rst = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", {bus.ref_ready, bus.valid, bus.q_bit, bus.r_bit, bus.code, bus.b,
                          bus.retire_valid, bus.retire_hit, bus.retire_id, bus.retire_beats,
                          bus.busy}, 0);
    rst = 1'b0;

    // No query loaded: an offered reference must never be taken
    bus.ref_valid = 1'b1; bus.ref_x = 4'h5; bus.ref_y = 4'h3; bus.ref_z = 4'h0; bus.ref_id = 16'd7;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("noquery_ready_valid", {bus.ref_ready, bus.valid}, 0);
    end

    bus.q_load = 1'b1; bus.q_x_in = 4'hA; bus.q_y_in = 4'h3; bus.q_z_in = 4'hF;
    mqx = 4'hA; mqy = 4'h3; mqz = 4'hF;
    tick();
    bus.q_load = 1'b0;
    chk("ready_after_load", bus.ref_ready, 1);

    for (int i = 0; i < 6; i++) run_one(sc[i], 1'b0, '0, '0, '0, '0, w);

    // Back-to-back references: the second is taken in the retire cycle of the first
    run_one(s1, 1'b1, s2.rx, s2.ry, s2.rz, s2.id, w);
    run_one(s2, 1'b0, '0, '0, '0, '0, w);
    chk("b2b_accept_wait", w, 0);

    // Verdict pulses while idle are ignored
    for (int i = 0; i < 4; i++) begin
      bus.terminate = (i != 2);
      bus.done      = (i >= 2);
      tick();
      chk("idle_pulse_no_retire", {bus.retire_valid, bus.busy, bus.valid}, 0);
    end
    bus.terminate = 1'b0; bus.done = 1'b0;

    // Reset in the middle of a stream drops the reference silently
    bus.ref_valid = 1'b1; bus.ref_x = 4'h7; bus.ref_y = 4'h1; bus.ref_z = 4'h2; bus.ref_id = 16'd9;
    chk("pre_reset_ready", bus.ref_ready, 1);
    tick();
    bus.ref_valid = 1'b0;
    repeat (5) tick();
    chk("pre_reset_beat6", {bus.valid, bus.code, bus.b}, {1'b1, 2'b11, 2'd1});
    rst = 1'b1;
    tick();
    chk("rst_outputs", {bus.ref_ready, bus.valid, bus.q_bit, bus.r_bit, bus.code, bus.b,
                        bus.retire_valid, bus.retire_hit, bus.retire_id, bus.retire_beats,
                        bus.busy}, 0);
    rst = 1'b0;
    tick();
    chk("post_reset_query_cleared", {bus.ref_ready, bus.retire_valid, bus.valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
